frame_compositor: RTL

- Downstream stage of the background mapper and sprite mappers; sits between them and the VGA pins.
- Selects the sprite pixel over the background per pixel and forces black outside the active area.
- Applies a frame-synchronous fade (brightness 0..15) driven by a small FSM.
- Delays hs/vs/blank from the VGA controller so they stay aligned with the mappers' pipelined RGB.

---
 rtl/frame_compositor.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/frame_compositor.sv
`default_nettype none
// ============================================================================
// Module   : frame_compositor
// Brief    : Final pixel stage between the background/sprite mappers and the
//            VGA pins. Picks sprite over background, blacks out the blanking
//            region, applies a frame-synchronous fade (levels 0..15), and
//            delays hs/vs/blank so they line up with the mappers' RGB.
// Revision : 1.0 - initial release
// ============================================================================
module frame_compositor #(
    parameter int SYNC_DELAY      = 2,
    parameter int FRAMES_PER_STEP = 4,
    parameter int RESET_LEVEL     = 15
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    input  logic       hs_in,
    input  logic       vs_in,
    input  logic       blank_in,
    input  logic [3:0] bg_red,
    input  logic [3:0] bg_green,
    input  logic [3:0] bg_blue,
    input  logic [3:0] sp_red,
    input  logic [3:0] sp_green,
    input  logic [3:0] sp_blue,
    input  logic       sp_valid,
    input  logic       fade_start,
    input  logic       fade_dir,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       hs_out,
    output logic       vs_out,
    output logic       blank_out,
    output logic [3:0] fade_level,
    output logic       fade_busy,
    output logic       fade_done
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        FADING = 1'b1
    } state_t;

    localparam logic [7:0] c_last_count  = 8'(FRAMES_PER_STEP - 1);
    localparam logic [3:0] c_reset_level = 4'(RESET_LEVEL);
    localparam logic [3:0] c_level_max   = 4'hF;
    localparam logic [3:0] c_level_min   = 4'h0;

    // Sync delay line: stage 0 takes the raw controller syncs
    logic [SYNC_DELAY-1:0] r_hs_dly;
    logic [SYNC_DELAY-1:0] r_vs_dly;
    logic [SYNC_DELAY-1:0] r_blank_dly;

    logic       r_hs_out;
    logic       r_vs_out;
    logic       r_blank_out;
    logic [3:0] r_red;
    logic [3:0] r_green;
    logic [3:0] r_blue;

    logic       r_vs_prev;
    logic       w_frame_tick;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_level;
    logic [3:0] w_level_nxt;
    logic [7:0] r_count;
    logic [7:0] w_count_nxt;
    logic       r_dir;
    logic       w_dir_nxt;
    logic       r_done;
    logic       w_done_nxt;
    logic [3:0] w_target;
    logic [3:0] w_start_target;
    logic [3:0] w_step_level;

    logic       w_blank_d;
    logic [3:0] w_sel_red;
    logic [3:0] w_sel_green;
    logic [3:0] w_sel_blue;

    // Brightness scaling: (c * (level + 1)) >> 4 in an 8-bit product, so
    // level 15 is an exact pass-through and level 0 is always black.
    function automatic logic [3:0] scale(input logic [3:0] c, input logic [3:0] lvl);
        logic [7:0] prod;
        prod = {4'b0000, c} * ({4'b0000, lvl} + 8'd1);
        return prod[7:4];
    endfunction

    genvar i;
    generate
        for (i = 0; i < SYNC_DELAY; i++) begin : g_sync_dly
            if (i == 0) begin : g_first
                // First delay stage captures the raw controller syncs
                always_ff @(posedge vga_clk or negedge reset_n) begin
                    if (!reset_n) begin
                        r_hs_dly[0]    <= 1'b1;
                        r_vs_dly[0]    <= 1'b1;
                        r_blank_dly[0] <= 1'b0;
                    end else begin
                        r_hs_dly[0]    <= hs_in;
                        r_vs_dly[0]    <= vs_in;
                        r_blank_dly[0] <= blank_in;
                    end
                end
            end else begin : g_next
                // Later stages shift the syncs one cycle further
                always_ff @(posedge vga_clk or negedge reset_n) begin
                    if (!reset_n) begin
                        r_hs_dly[i]    <= 1'b1;
                        r_vs_dly[i]    <= 1'b1;
                        r_blank_dly[i] <= 1'b0;
                    end else begin
                        r_hs_dly[i]    <= r_hs_dly[i-1];
                        r_vs_dly[i]    <= r_vs_dly[i-1];
                        r_blank_dly[i] <= r_blank_dly[i-1];
                    end
                end
            end
        end
    endgenerate

    // Delayed blank is aligned with the mapper RGB arriving this cycle
    assign w_blank_d = r_blank_dly[SYNC_DELAY-1];

    // Colour select: black outside the active area, sprite wins over background
    always_comb begin
        w_sel_red   = 4'h0;
        w_sel_green = 4'h0;
        w_sel_blue  = 4'h0;
        if (w_blank_d) begin
            if (sp_valid) begin
                w_sel_red   = sp_red;
                w_sel_green = sp_green;
                w_sel_blue  = sp_blue;
            end else begin
                w_sel_red   = bg_red;
                w_sel_green = bg_green;
                w_sel_blue  = bg_blue;
            end
        end
    end

    // Output register for the faded pixel and the delayed syncs
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_red       <= 4'h0;
            r_green     <= 4'h0;
            r_blue      <= 4'h0;
            r_hs_out    <= 1'b1;
            r_vs_out    <= 1'b1;
            r_blank_out <= 1'b0;
        end else begin
            r_red       <= scale(w_sel_red,   r_level);
            r_green     <= scale(w_sel_green, r_level);
            r_blue      <= scale(w_sel_blue,  r_level);
            r_hs_out    <= r_hs_dly[SYNC_DELAY-1];
            r_vs_out    <= r_vs_dly[SYNC_DELAY-1];
            r_blank_out <= w_blank_d;
        end
    end

    // Remember raw vs to detect the start of a new frame
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vs_prev <= 1'b1;
        end else begin
            r_vs_prev <= vs_in;
        end
    end

    // Frame boundary strobe on the falling edge of raw vs
    assign w_frame_tick = r_vs_prev & ~vs_in;

    // Fade FSM state and datapath registers
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_level <= c_reset_level;
            r_count <= 8'd0;
            r_dir   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_level <= w_level_nxt;
            r_count <= w_count_nxt;
            r_dir   <= w_dir_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Fade FSM next-state: start/ignore requests, count frames, step level
    always_comb begin
        w_state_nxt    = r_state;
        w_level_nxt    = r_level;
        w_count_nxt    = r_count;
        w_dir_nxt      = r_dir;
        w_done_nxt     = 1'b0;
        w_target       = r_dir ? c_level_max : c_level_min;
        w_start_target = fade_dir ? c_level_max : c_level_min;
        // Saturating single step toward the latched direction
        if (r_dir) begin
            w_step_level = (r_level == c_level_max) ? r_level : r_level + 4'd1;
        end else begin
            w_step_level = (r_level == c_level_min) ? r_level : r_level - 4'd1;
        end

        case (r_state)
            IDLE: begin
                if (fade_start) begin
                    w_dir_nxt = fade_dir;
                    if (r_level == w_start_target) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = FADING;
                        w_count_nxt = 8'd0;
                    end
                end
            end
            FADING: begin
                if (w_frame_tick) begin
                    if (r_count == c_last_count) begin
                        w_level_nxt = w_step_level;
                        w_count_nxt = 8'd0;
                        if (w_step_level == w_target) begin
                            w_state_nxt = IDLE;
                            w_done_nxt  = 1'b1;
                        end
                    end else begin
                        w_count_nxt = r_count + 8'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign red        = r_red;
    assign green      = r_green;
    assign blue       = r_blue;
    assign hs_out     = r_hs_out;
    assign vs_out     = r_vs_out;
    assign blank_out  = r_blank_out;
    assign fade_level = r_level;
    assign fade_busy  = (r_state == FADING);
    assign fade_done  = r_done;

endmodule
`default_nettype wire
